// File: rtl/scan_doubler.sv
// scan_doubler: captures 15 kHz lines into a ping-pong buffer and replays each line twice at 2x rate.
// Optional macro SCANLINE_EN halves each colour channel on the second output line of each pair.
module scan_doubler #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned COLOR_W = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PCE,
    input  logic [COLOR_W-1:0] iRGB,
    input  logic               iHBLK,
    input  logic               iVBLK,
    input  logic               iHSYN,
    input  logic               iVSYN,
    output logic [COLOR_W-1:0] oRGB,
    output logic               oHBLK,
    output logic               oVBLK,
    output logic               oHSYN,
    output logic               oVSYN
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned ENT_W = COLOR_W + 1;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [ENT_W-1:0]  line_buf [2*DEPTH];
    logic [ENT_W-1:0]  rd_q;
    logic [ADDR_W-1:0] icnt;
    logic [CNT_W-1:0]  linelen, hswid, hs_lo, hs_meas, ocnt;
    logic              wbank, prev_hsyn, seen_one, valid;
    logic              s1_valid, s1_hsyn, s1_vs, s1_vb;

    logic              line_start_c, wen_c, wbank_c;
    logic [ADDR_W-1:0] waddr_c, rd_addr_c;
    logic [COLOR_W-1:0] pix_c;

    assign line_start_c = PCE && prev_hsyn && !iHSYN;
    assign wbank_c      = line_start_c ? ~wbank : wbank;
    assign rd_addr_c    = ocnt[ADDR_W] ? ADDR_MAX : ocnt[ADDR_W-1:0];

    // Write address: a line start lands at entry 0 of the fresh bank; writes stop once icnt saturates.
    always_comb begin
        wen_c   = 1'b0;
        waddr_c = icnt;
        if (line_start_c) begin
            wen_c   = 1'b1;
            waddr_c = '0;
        end else if (PCE && icnt != ADDR_MAX) begin
            wen_c   = 1'b1;
            waddr_c = icnt + ADDR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (wen_c)
            line_buf[{wbank_c, waddr_c}] <= {iHBLK, iRGB};
        rd_q <= line_buf[{~wbank, rd_addr_c}];
    end

    // Input side: line length, hsync width measurement and bank swap.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            icnt      <= '0;
            linelen   <= '0;
            hswid     <= '0;
            hs_lo     <= '0;
            hs_meas   <= '0;
            wbank     <= 1'b0;
            prev_hsyn <= 1'b1;
            seen_one  <= 1'b0;
            valid     <= 1'b0;
        end else if (PCE) begin
            prev_hsyn <= iHSYN;
            if (!iHSYN)
                hs_lo <= prev_hsyn ? CNT_W'(1) : ((hs_lo == CNT_MAX) ? hs_lo : hs_lo + CNT_W'(1));
            else if (!prev_hsyn)
                hs_meas <= hs_lo;
            if (line_start_c) begin
                linelen  <= CNT_W'(icnt) + CNT_W'(1);
                hswid    <= hs_meas;
                icnt     <= '0;
                wbank    <= ~wbank;
                seen_one <= 1'b1;
                valid    <= valid | seen_one;
            end else if (icnt != ADDR_MAX) begin
                icnt <= icnt + ADDR_W'(1);
            end
        end
    end

    // Output counter: forced restart on input line start, otherwise wraps at linelen-1.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            ocnt <= '0;
        else if (line_start_c || ocnt == linelen - CNT_W'(1))
            ocnt <= '0;
        else
            ocnt <= ocnt + CNT_W'(1);
    end

    // Stage 1: side info aligned with the registered buffer read.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid <= 1'b0;
            s1_hsyn  <= 1'b1;
            s1_vs    <= 1'b1;
            s1_vb    <= 1'b1;
        end else begin
            s1_valid <= valid;
            s1_hsyn  <= !(ocnt < hswid);
            if (ocnt == '0) begin
                s1_vs <= iVSYN;
                s1_vb <= iVBLK;
            end
        end
    end

`ifdef SCANLINE_EN
    localparam logic [COLOR_W-1:0] DIM_MASK = COLOR_W'(8'h6D);
    logic half, s1_half;

    // Tracks which line of the output pair is being produced.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            half    <= 1'b0;
            s1_half <= 1'b0;
        end else begin
            s1_half <= half;
            if (line_start_c)
                half <= 1'b0;
            else if (ocnt == linelen - CNT_W'(1))
                half <= ~half;
        end
    end

    assign pix_c = s1_half ? ((rd_q[COLOR_W-1:0] >> 1) & DIM_MASK) : rd_q[COLOR_W-1:0];
`else
    assign pix_c = rd_q[COLOR_W-1:0];
`endif

    // Stage 2: registered outputs, held at idle values until two line starts have been seen.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            oRGB  <= '0;
            oHBLK <= 1'b1;
            oVBLK <= 1'b1;
            oHSYN <= 1'b1;
            oVSYN <= 1'b1;
        end else if (!s1_valid) begin
            oRGB  <= '0;
            oHBLK <= 1'b1;
            oVBLK <= 1'b1;
            oHSYN <= 1'b1;
            oVSYN <= 1'b1;
        end else begin
            oRGB  <= (rd_q[COLOR_W] || s1_vb) ? '0 : pix_c;
            oHBLK <= rd_q[COLOR_W];
            oVBLK <= s1_vb;
            oHSYN <= s1_hsyn;
            oVSYN <= s1_vs;
        end
    end
endmodule

// File: tb/tb_scan_doubler.sv
// tb_scan_doubler: randomized line stimulus checked against a line-level reference model.
`timescale 1ns/1ps
module tb_scan_doubler;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned COLOR_W = 8;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int MAXC  = 40000;

    logic CLK = 1'b0;
    logic RESET, PCE, iHBLK, iVBLK, iHSYN, iVSYN;
    logic [COLOR_W-1:0] iRGB, oRGB;
    logic oHBLK, oVBLK, oHSYN, oVSYN;

    always #5 CLK = ~CLK;

    scan_doubler #(.ADDR_W(ADDR_W), .COLOR_W(COLOR_W)) dut (
        .CLK(CLK), .RESET(RESET), .PCE(PCE), .iRGB(iRGB),
        .iHBLK(iHBLK), .iVBLK(iVBLK), .iHSYN(iHSYN), .iVSYN(iVSYN),
        .oRGB(oRGB), .oHBLK(oHBLK), .oVBLK(oVBLK), .oHSYN(oHSYN), .oVSYN(oVSYN)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Per-edge expectations: what the output pipeline should show two edges later.
    bit         exp_valid [MAXC];
    logic [8:0] exp_ent   [MAXC];
    bit         exp_half  [MAXC];
    bit         exp_hs    [MAXC];
    int         exp_e0    [MAXC];
    bit         ivs_arr   [MAXC];
    bit         ivb_arr   [MAXC];

    // Line-level model: samples captured since the last line start and the line before it.
    logic [8:0] cur_cap[$];
    logic [8:0] prev_cap[$];
    int lprev = 0, hsw_exp = 0, last_w = 0, nstarts = 0, since = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_rgb"},  32'(oRGB), 32'd0);
        check({pfx, "_hblk"}, 32'(oHBLK), 32'd1);
        check({pfx, "_vblk"}, 32'(oVBLK), 32'd1);
        check({pfx, "_hsyn"}, 32'(oHSYN), 32'd1);
        check({pfx, "_vsyn"}, 32'(oVSYN), 32'd1);
    endtask

    task automatic compare(input int t);
        logic [7:0] px;
        bit vb, vs, hb;
        if (!exp_valid[t]) begin
            check_idle("quiet");
            return;
        end
        vb = ivb_arr[exp_e0[t] + 1];
        vs = ivs_arr[exp_e0[t] + 1];
        hb = exp_ent[t][8];
        px = exp_ent[t][7:0];
`ifdef SCANLINE_EN
        if (exp_half[t])
            px = {3'(px[7:5] / 2), 3'(px[4:2] / 2), 2'(px[1:0] / 2)};
`endif
        if (hb || vb)
            px = 8'd0;
        check("rgb",  32'(oRGB),  32'(px));
        check("hblk", 32'(oHBLK), 32'(hb));
        check("vblk", 32'(oVBLK), 32'(vb));
        check("hsyn", 32'(oHSYN), 32'(exp_hs[t]));
        check("vsyn", 32'(oVSYN), 32'(vs));
    endtask

    // Drive one CLK worth of inputs, update the model for that edge, then check two edges back.
    task automatic step(input bit pce, input logic [7:0] rgb, input bit hb, input bit vb,
                        input bit hs, input bit vs, input bit start, input int w);
        int e, oc;
        PCE = pce; iRGB = rgb; iHBLK = hb; iVBLK = vb; iHSYN = hs; iVSYN = vs;
        e = cyc + 1;
        if (e >= MAXC - 4) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", e, MAXC - 4);
            $fatal(1, "cycle budget exhausted");
        end
        ivs_arr[e] = vs;
        ivb_arr[e] = vb;
        if (RESET) begin
            nstarts = 0; lprev = 0; hsw_exp = 0; last_w = 0; since = 0;
            cur_cap.delete(); prev_cap.delete();
        end else begin
            if (pce && start) begin
                prev_cap = cur_cap;
                lprev    = cur_cap.size();
                hsw_exp  = last_w;
                last_w   = w;
                nstarts++;
                cur_cap.delete();
                since = 0;
            end else begin
                since++;
            end
            if (pce && cur_cap.size() < DEPTH)
                cur_cap.push_back({hb, rgb});
        end
        exp_valid[e] = !RESET && nstarts >= 2 && lprev > 0;
        oc           = (lprev > 0) ? since % lprev : 0;
        exp_ent[e]   = (lprev > 0) ? prev_cap[oc] : 9'd0;
        exp_half[e]  = (lprev > 0) && ((since / lprev) % 2 == 1);
        exp_hs[e]    = !(oc < hsw_exp);
        exp_e0[e]    = e - oc;
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        if (cyc >= 2)
            compare(cyc - 2);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    endtask

    // mode: 0 random pixels, 1 ramp, 2 constant 8'hFF. w=0 means no hsync pulse (sync lost).
    task automatic drive_line(input int len, input int w, input int hb_start,
                              input bit vb, input bit vs, input int mode, input int stop_at);
        logic [7:0] px;
        bit hbk, hs;
        for (int p = 0; p < len; p++) begin
            if (p == stop_at)
                return;
            px  = (mode == 1) ? 8'(p) : (mode == 2) ? 8'hFF : 8'($urandom);
            hbk = (p >= hb_start);
            hs  = !(w > 0 && p < w);
            step(1'b1, px, hbk, vb, hs, vs, (w > 0 && p == 0), w);
            step(1'b0, px, hbk, vb, hs, vs, 1'b0, w);
        end
    endtask

    task automatic mid_reset();
        RESET = 1'b1;
        #1;
        check_idle("rst_async");
        exp_valid[cyc] = 1'b0;
        if (cyc > 0)
            exp_valid[cyc - 1] = 1'b0;
        idle(3);
        RESET = 1'b0;
        idle(4);
    endtask

    initial begin
        RESET = 1'b1; PCE = 1'b0; iRGB = '0;
        iHBLK = 1'b1; iVBLK = 1'b1; iHSYN = 1'b1; iVSYN = 1'b1;
        #1;
        check_idle("rst_init");
        @(negedge CLK);
        idle(3);
        RESET = 1'b0;
        idle(5);

        // Steady 396-pixel lines, 32-pixel hsync.
        for (int i = 0; i < 3; i++)
            drive_line(396, 32, 396, 1'b0, 1'b1, 0, -1);
        drive_line(396, 32, 396, 1'b0, 1'b1, 1, -1);
        drive_line(396, 32, 258, 1'b1, 1'b1, 0, -1);
        drive_line(396, 32, 258, 1'b0, 1'b0, 0, -1);
        drive_line(396, 32, 396, 1'b0, 1'b1, 2, -1);
        drive_line(396, 32, 396, 1'b0, 1'b1, 0, -1);

        // Randomized line lengths, sync widths, blanking and vertical flags.
        for (int i = 0; i < 6; i++)
            drive_line($urandom_range(300, 420), $urandom_range(8, 48), $urandom_range(200, 420),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 0, -1);

        // Odd length, overflow, lost sync.
        drive_line(397, 20, 397, 1'b0, 1'b1, 0, -1);
        drive_line(600, 32, 600, 1'b0, 1'b1, 1, -1);
        drive_line(396, 32, 396, 1'b0, 1'b1, 0, -1);
        drive_line(396, 0,  396, 1'b0, 1'b1, 0, -1);
        drive_line(396, 24, 396, 1'b0, 1'b1, 0, -1);
        drive_line(396, 32, 258, 1'b0, 1'b1, 0, -1);

        // Reset in the middle of a line, then restart.
        drive_line(396, 32, 396, 1'b0, 1'b1, 0, 200);
        mid_reset();
        for (int i = 0; i < 4; i++)
            drive_line(396, 32, 300, 1'b0, 1'b1, 0, -1);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
